// File: rtl/dmem_responder_pkg.sv
// Shared constants and types for the data-memory responder: MMIO slot offsets,
// address-region classification and the game-state register width.
package dmem_pkg;

  localparam logic [3:0] OFF_BUTTONS = 4'h0;
  localparam logic [3:0] OFF_SCORE   = 4'h1;
  localparam logic [3:0] OFF_GSTATE  = 4'h2;
  localparam logic [3:0] OFF_TIMER   = 4'h3;

  localparam int GSTATE_W = 4;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_UNMAPPED
  } region_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Memory-stage data port: address/write data/write enable toward the responder,
// registered read data and unmapped-access pulse back to the CPU.
interface dmem_if #(
  parameter int DATA_WIDTH = 32
);

  logic [31:0]           address_dmem;
  logic [DATA_WIDTH-1:0] d_dmem;
  logic                  DMwe;
  logic [DATA_WIDTH-1:0] q_dmem;
  logic                  bus_err;

  modport master (
    output address_dmem, d_dmem, DMwe,
    input  q_dmem, bus_err
  );

  modport slave (
    input  address_dmem, d_dmem, DMwe,
    output q_dmem, bus_err
  );

endinterface

// File: rtl/dmem_responder_btn_sync_latch.sv
// Two-flop synchronizer for an asynchronous button, with rising-edge detect feeding
// a sticky latch that is cleared by software; a same-cycle set beats the clear.
module btn_sync_latch (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  input  logic clr,
  output logic sync,
  output logic latch
);

  logic meta_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
      latch   <= 1'b0;
    end else begin
      // p0 -> p1: metastability filter; p1 -> p2: history for edge detect
      meta_p0 <= btn;
      sync_p1 <= meta_p0;
      prev_p2 <= sync_p1;
      if (sync_p1 && !prev_p2) begin
        latch <= 1'b1;
      end else if (clr) begin
        latch <= 1'b0;
      end
    end
  end

  assign sync = sync_p1;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM plus a 16-slot MMIO page for game I/O,
// one-cycle registered read. Optional free-running timer at slot 0x3 under MMIO_TIMER_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] MMIO_BASE  = 32'h0000F000
) (
  input  logic                  clock,
  input  logic                  reset,
  dmem_if.slave                 bus,
  input  logic                  btn_jump,
  input  logic                  btn_duck,
  output logic [DATA_WIDTH-1:0] score_out,
  output logic [GSTATE_W-1:0]   game_state_out
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  region_e               region;
  logic [3:0]            offset;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  btn_rd;
  logic [DATA_WIDTH-1:0] rdata_p0;

  logic [DATA_WIDTH-1:0] score;
  logic [GSTATE_W-1:0]   gstate;

  logic jump_sync;
  logic jump_latch;
  logic duck_sync;
  logic duck_latch_unused;

`ifdef MMIO_TIMER_EN
  logic [31:0] timer;
`endif

  assign offset  = bus.address_dmem[3:0];
  assign ram_idx = bus.address_dmem[ADDR_WIDTH-1:0];

  always_comb begin
    region = REG_UNMAPPED;
    if (bus.address_dmem[31:ADDR_WIDTH] == '0) begin
      region = REG_RAM;
    end else if (bus.address_dmem[31:4] == MMIO_BASE[31:4]) begin
      region = REG_MMIO;
    end
  end

  // Only a plain read of BUTTONS acknowledges the jump latch.
  assign btn_rd = (region == REG_MMIO) && (offset == OFF_BUTTONS) && !bus.DMwe;

  btn_sync_latch u_jump (
    .clock (clock),
    .reset (reset),
    .btn   (btn_jump),
    .clr   (btn_rd),
    .sync  (jump_sync),
    .latch (jump_latch)
  );

  btn_sync_latch u_duck (
    .clock (clock),
    .reset (reset),
    .btn   (btn_duck),
    .clr   (1'b0),
    .sync  (duck_sync),
    .latch (duck_latch_unused)
  );

`ifdef MMIO_TIMER_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      timer <= '0;
    end else begin
      timer <= timer + 32'd1;
    end
  end
`endif

  // p0: select read data from the pre-edge state, giving read-first behaviour
  always_comb begin
    rdata_p0 = '0;
    unique case (region)
      REG_RAM: rdata_p0 = mem[ram_idx];
      REG_MMIO: begin
        case (offset)
          OFF_BUTTONS: rdata_p0[2:0]          = {duck_sync, jump_sync, jump_latch};
          OFF_SCORE:   rdata_p0               = score;
          OFF_GSTATE:  rdata_p0[GSTATE_W-1:0] = gstate;
`ifdef MMIO_TIMER_EN
          OFF_TIMER:   rdata_p0               = DATA_WIDTH'(timer);
`endif
          default:     rdata_p0               = '0;
        endcase
      end
      default: rdata_p0 = '0;
    endcase
  end

  // RAM contents are deliberately left out of reset; reset only blocks the write.
  always_ff @(posedge clock) begin
    if (!reset && bus.DMwe && (region == REG_RAM)) begin
      mem[ram_idx] <= bus.d_dmem;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      score  <= '0;
      gstate <= '0;
    end else if (bus.DMwe && (region == REG_MMIO)) begin
      if (offset == OFF_SCORE) begin
        score <= bus.d_dmem;
      end
      if (offset == OFF_GSTATE) begin
        gstate <= bus.d_dmem[GSTATE_W-1:0];
      end
    end
  end

  // p0 -> p1: registered response
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.q_dmem  <= '0;
      bus.bus_err <= 1'b0;
    end else begin
      bus.q_dmem  <= rdata_p0;
      bus.bus_err <= (region == REG_UNMAPPED);
    end
  end

  assign score_out      = score;
  assign game_state_out = gstate;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_dmem_responder;

  logic clk;
  logic reset;
  logic btn_jump;
  logic btn_duck;
  logic [31:0] score_out;
  logic [3:0]  game_state_out;

  dmem_if #(.DATA_WIDTH(32)) bus ();

  dmem_responder dut (
    .clock          (clk),
    .reset          (reset),
    .bus            (bus),
    .btn_jump       (btn_jump),
    .btn_duck       (btn_duck),
    .score_out      (score_out),
    .game_state_out (game_state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural model: word memory as a sparse map, registers as plain variables,
  // button synchronizers as a short history of sampled button levels.
  logic [31:0] mmem [int];
  logic [31:0] exp_q;
  bit          exp_q_known;
  bit          exp_err;
  logic [31:0] m_score;
  logic [3:0]  m_gstate;
  bit          m_latch;
  bit          jh1, jh2, jh3, dh1, dh2;
  logic [31:0] tcount;
  bit          mvalid = 0;

  always @(posedge clk) begin
    logic [31:0] a;
    logic [31:0] d;
    bit          we, rise, rd_btn;
    int          idx;
    if (reset) begin
      exp_q = 0; exp_q_known = 1; exp_err = 0;
      m_score = 0; m_gstate = 0; m_latch = 0;
      jh1 = 0; jh2 = 0; jh3 = 0; dh1 = 0; dh2 = 0;
      tcount = 0;
      mvalid = 1;
    end else begin
      a = bus.address_dmem; d = bus.d_dmem; we = bus.DMwe;
      idx = int'(a[11:0]);
      rise = jh2 && !jh3;
      rd_btn = 0;
      exp_q = 0; exp_q_known = 1; exp_err = 0;
      if (a < 32'h1000) begin
        if (mmem.exists(idx)) exp_q = mmem[idx];
        else exp_q_known = 0;
        if (we) mmem[idx] = d;
      end else if (a[31:4] == 28'h0000F00) begin
        case (a[3:0])
          4'h0: begin exp_q = {29'b0, dh2, jh2, m_latch}; rd_btn = !we; end
          4'h1: exp_q = m_score;
          4'h2: exp_q = {28'b0, m_gstate};
`ifdef MMIO_TIMER_EN
          4'h3: exp_q = tcount;
`endif
          default: exp_q = 0;
        endcase
        if (we && a[3:0] == 4'h1) m_score = d;
        if (we && a[3:0] == 4'h2) m_gstate = d[3:0];
      end else begin
        exp_err = 1;
      end
      if (rise) m_latch = 1;
      else if (rd_btn) m_latch = 0;
      tcount = tcount + 1;
      jh3 = jh2; jh2 = jh1; jh1 = btn_jump;
      dh2 = dh1; dh1 = btn_duck;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      if (exp_q_known) chk("model_q", bus.q_dmem, exp_q);
      chk("model_bus_err", {31'b0, bus.bus_err}, {31'b0, exp_err});
      chk("model_score", score_out, m_score);
      chk("model_gstate", {28'b0, game_state_out}, {28'b0, m_gstate});
    end
  end

  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic we);
    bus.address_dmem = a;
    bus.d_dmem = d;
    bus.DMwe = we;
    @(negedge clk);
  endtask

  logic [31:0] t0, t1;

  initial begin
    reset = 1; btn_jump = 0; btn_duck = 0;
    bus.address_dmem = 32'hF004; bus.d_dmem = 0; bus.DMwe = 0;
    repeat (3) @(negedge clk);
    chk("reset_q", bus.q_dmem, 32'h0);
    chk("reset_bus_err", {31'b0, bus.bus_err}, 32'h0);
    chk("reset_score", score_out, 32'h0);
    chk("reset_gstate", {28'b0, game_state_out}, 32'h0);
    reset = 0;

    step(32'h005, 32'hDEADBEEF, 1);
    step(32'h005, 32'h0, 0);
    chk("ram_write_read", bus.q_dmem, 32'hDEADBEEF);

    step(32'h010, 32'h1, 1);
    step(32'h010, 32'h2, 1);
    chk("read_first_old", bus.q_dmem, 32'h1);
    step(32'h010, 32'h0, 0);
    chk("read_first_new", bus.q_dmem, 32'h2);

    step(32'hF001, 32'd42, 1);
    step(32'hF002, 32'hFFFF_FFF5, 1);
    chk("score_out", score_out, 32'd42);
    step(32'hF002, 32'h0, 0);
    chk("gstate_out", {28'b0, game_state_out}, 32'h5);
    chk("gstate_read", bus.q_dmem, 32'h5);

    btn_jump = 1; step(32'hF004, 0, 0);
    btn_jump = 0;
    repeat (4) step(32'hF004, 0, 0);
    step(32'hF000, 0, 0);
    chk("jump_latch_set", {31'b0, bus.q_dmem[0]}, 32'h1);
    step(32'hF000, 0, 0);
    chk("jump_latch_clr", {31'b0, bus.q_dmem[0]}, 32'h0);

    btn_jump = 1; step(32'hF004, 0, 0);
    btn_jump = 0;
    repeat (4) step(32'hF004, 0, 0);
    btn_jump = 1; step(32'hF004, 0, 0);
    btn_jump = 0; step(32'hF004, 0, 0);
    step(32'hF000, 0, 0);
    chk("collide_read", {31'b0, bus.q_dmem[0]}, 32'h1);
    step(32'hF000, 0, 0);
    chk("collide_kept", {31'b0, bus.q_dmem[0]}, 32'h1);
    step(32'hF000, 0, 0);
    chk("collide_cleared", {31'b0, bus.q_dmem[0]}, 32'h0);

    step(32'h000, 32'hA5, 1);
    step(32'h0001_0000, 32'd7, 1);
    chk("unmapped_err", {31'b0, bus.bus_err}, 32'h1);
    chk("unmapped_q", bus.q_dmem, 32'h0);
    step(32'h000, 0, 0);
    chk("unmapped_err_pulse", {31'b0, bus.bus_err}, 32'h0);
    chk("unmapped_no_alias", bus.q_dmem, 32'hA5);
    chk("unmapped_score", score_out, 32'd42);

    step(32'h020, 32'h1111_1111, 1);
    reset = 1; step(32'h020, 32'h99, 1);
    reset = 0;
    chk("reset_mid_score", score_out, 32'h0);
    step(32'h020, 0, 0);
    chk("reset_mid_write", bus.q_dmem, 32'h1111_1111);

    step(32'hF003, 0, 0);
    t0 = bus.q_dmem;
    repeat (9) step(32'hF004, 0, 0);
    step(32'hF003, 0, 0);
    t1 = bus.q_dmem;
`ifdef MMIO_TIMER_EN
    chk("timer_delta", t1 - t0, 32'd10);
`else
    chk("timer_absent0", t0, 32'h0);
    chk("timer_absent1", t1, 32'h0);
`endif

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 4)       a = 32'($urandom_range(0, 15));
      else if (sel == 4) a = 32'h0000_0FFF;
      else if (sel < 8)  a = 32'h0000_F000 | 32'($urandom_range(0, 15));
      else if (sel == 8) a = 32'h0000_1000;
      else               a = $urandom;
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) btn_jump = ~btn_jump;
      if ($urandom_range(0, 7) == 0) btn_duck = ~btn_duck;
      step(a, $urandom, 1'($urandom_range(0, 1)));
    end
    reset = 0;
    step(32'hF004, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
